// File: rtl/btn_event_if.sv
// rtl/btn_event_if.sv - button-level input and event-pulse outputs of btn_event
interface btn_event_if;
    logic       btn;
    logic       short_p;
    logic       long_p;
    logic       dbl_p;
    logic       rep_p;
    logic [7:0] ev_cnt;

    modport master (
        output btn,
        input  short_p,
        input  long_p,
        input  dbl_p,
        input  rep_p,
        input  ev_cnt
    );

    modport slave (
        input  btn,
        output short_p,
        output long_p,
        output dbl_p,
        output rep_p,
        output ev_cnt
    );
endinterface

// File: rtl/btn_event.sv
// rtl/btn_event.sv - classifies a clean button level into short/long/double(/repeat) pulses
// Optional auto-repeat while held long: define BTN_REPEAT_EN.
module btn_event #(
    parameter int LONG_CYC = 8,
    parameter int DBL_GAP  = 6,
    parameter int REP_CYC  = 4,
    parameter int CNT_W    = 8
) (
    input  logic      clk,
    input  logic      rst,
    btn_event_if.slave bus
);

    if (LONG_CYC < 2 || DBL_GAP < 1 || REP_CYC < 1 ||
        LONG_CYC > (2**CNT_W - 1) || DBL_GAP > (2**CNT_W - 1) ||
        REP_CYC > (2**CNT_W - 1)) begin : g_bad_params
        $error("btn_event: parameter out of range");
    end

    typedef enum logic [2:0] {
        IDLE,
        PRESS,
        GAP,
        LONG,
        WAIT_REL
    } state_t;

    // Thresholds compare against the count already held, so the deciding
    // sample is the LONG_CYC-th high / DBL_GAP-th low one.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DBL_GAP - 1);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    state_t           state_q,  state_d;
    logic [CNT_W-1:0] hold_q,   hold_d;
    logic [CNT_W-1:0] gap_q,    gap_d;
    logic             short_q,  short_d;
    logic             long_q,   long_d;
    logic             dbl_q,    dbl_d;
    logic             rep_q,    rep_d;
    logic [7:0]       ev_cnt_q, ev_cnt_d;
    logic             any_pulse;

`ifdef BTN_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REP_CYC - 1);
    logic [CNT_W-1:0] rcnt_q, rcnt_d;
`endif

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        gap_d   = gap_q;
        short_d = 1'b0;
        long_d  = 1'b0;
        dbl_d   = 1'b0;
        rep_d   = 1'b0;
`ifdef BTN_REPEAT_EN
        rcnt_d  = rcnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.btn) begin
                    state_d = PRESS;
                    hold_d  = ONE;
                end
            end
            PRESS: begin
                if (bus.btn) begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = LONG;
                        long_d  = 1'b1;
`ifdef BTN_REPEAT_EN
                        rcnt_d  = '0;
`endif
                    end else begin
                        hold_d = hold_q + ONE;
                    end
                end else if (DBL_GAP == 1) begin
                    state_d = IDLE;
                    short_d = 1'b1;
                end else begin
                    state_d = GAP;
                    gap_d   = ONE;
                end
            end
            GAP: begin
                if (bus.btn) begin
                    state_d = WAIT_REL;
                    dbl_d   = 1'b1;
                end else if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                    short_d = 1'b1;
                end else begin
                    gap_d = gap_q + ONE;
                end
            end
            LONG: begin
                if (!bus.btn) begin
                    state_d = IDLE;
                end else begin
`ifdef BTN_REPEAT_EN
                    if (rcnt_q == REP_LAST) begin
                        rep_d  = 1'b1;
                        rcnt_d = '0;
                    end else begin
                        rcnt_d = rcnt_q + ONE;
                    end
`endif
                end
            end
            WAIT_REL: begin
                if (!bus.btn) begin
                    state_d = IDLE;
                end
            end
            default: state_d = WAIT_REL;
        endcase
        any_pulse = short_d | long_d | dbl_d | rep_d;
        ev_cnt_d  = ev_cnt_q + {7'b0, any_pulse};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= WAIT_REL;
            hold_q   <= '0;
            gap_q    <= '0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            dbl_q    <= 1'b0;
            rep_q    <= 1'b0;
            ev_cnt_q <= 8'd0;
`ifdef BTN_REPEAT_EN
            rcnt_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            gap_q    <= gap_d;
            short_q  <= short_d;
            long_q   <= long_d;
            dbl_q    <= dbl_d;
            rep_q    <= rep_d;
            ev_cnt_q <= ev_cnt_d;
`ifdef BTN_REPEAT_EN
            rcnt_q   <= rcnt_d;
`endif
        end
    end

    assign bus.short_p = short_q;
    assign bus.long_p  = long_q;
    assign bus.dbl_p   = dbl_q;
    assign bus.rep_p   = rep_q;
    assign bus.ev_cnt  = ev_cnt_q;

endmodule

// File: tb/tb_btn_event.sv
// tb/tb_btn_event.sv - table-driven and scoreboard bench for btn_event
module tb_btn_event;

    localparam logic [3:0] EV_N = 4'b0000;
    localparam logic [3:0] EV_S = 4'b1000;
    localparam logic [3:0] EV_L = 4'b0100;
    localparam logic [3:0] EV_D = 4'b0010;
    localparam logic [3:0] EV_R = 4'b0001;

    logic clk = 1'b0;
    logic rst;

    btn_event_if bus ();

    btn_event #(
        .LONG_CYC(8),
        .DBL_GAP (6),
        .REP_CYC (4),
        .CNT_W   (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         samp;
        logic [3:0] ev;
    } exp_t;

    typedef struct {
        int         hi;
        int         lo;
        int         hi2;
        int         lo2;
        logic [3:0] ev;
        int         at;
    } vec_t;

    exp_t       expq[$];
    vec_t       vecs[8];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         samp     = 0;
    int         n_pulses = 0;
    logic [7:0] exp_ev   = 8'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at sample %0d: got %0h, expected %0h", name, samp, act, req);
        end
    endtask

    task automatic expect_ev(input int at, input logic [3:0] ev);
        exp_t e;
        e.samp = samp + at;
        e.ev   = ev;
        expq.push_back(e);
    endtask

    // Each sample: drive btn, take the edge, then compare against the scoreboard.
    task automatic drive(input logic b, input int n);
        logic [3:0] want;
        logic [3:0] got;
        for (int i = 0; i < n; i++) begin
            bus.btn = b;
            @(posedge clk);
            samp++;
            #1;
            want = EV_N;
            if (expq.size() > 0 && expq[0].samp == samp) begin
                want = expq[0].ev;
                void'(expq.pop_front());
            end
            got = {bus.short_p, bus.long_p, bus.dbl_p, bus.rep_p};
            if (want != EV_N) exp_ev++;
            if (got != EV_N) n_pulses++;
            check("pulses", {28'd0, got}, {28'd0, want});
            check("ev_cnt", {24'd0, bus.ev_cnt}, {24'd0, exp_ev});
        end
    endtask

    task automatic check_zero(input string name);
        check({name, "_pulses"}, {28'd0, bus.short_p, bus.long_p, bus.dbl_p, bus.rep_p}, 32'd0);
        check({name, "_ev_cnt"}, {24'd0, bus.ev_cnt}, 32'd0);
    endtask

    initial begin
        int p0;

        vecs[0] = '{3, 6, 0, 2, EV_S, 9};
        vecs[1] = '{3, 2, 2, 3, EV_D, 6};
        vecs[2] = '{1, 6, 0, 1, EV_S, 7};
        vecs[3] = '{7, 6, 0, 1, EV_S, 13};
        vecs[4] = '{3, 5, 1, 2, EV_D, 9};
        vecs[5] = '{2, 1, 12, 2, EV_D, 4};
        vecs[6] = '{8, 3, 0, 0, EV_L, 8};
        vecs[7] = '{9, 2, 0, 0, EV_L, 8};

        rst     = 1'b0;
        bus.btn = 1'b0;
        #2;
        check_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 2);

        for (int v = 0; v < 8; v++) begin
            if (vecs[v].at > 0) expect_ev(vecs[v].at, vecs[v].ev);
            drive(1'b1, vecs[v].hi);
            drive(1'b0, vecs[v].lo);
            drive(1'b1, vecs[v].hi2);
            drive(1'b0, vecs[v].lo2);
        end

        expect_ev(8, EV_L);
`ifdef BTN_REPEAT_EN
        expect_ev(12, EV_R);
        expect_ev(16, EV_R);
        expect_ev(20, EV_R);
`endif
        drive(1'b1, 20);
        drive(1'b0, 2);

        bus.btn = 1'b1;
        rst     = 1'b0;
        exp_ev  = 8'd0;
        #1;
        check_zero("rst_held");
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 20);
        drive(1'b0, 2);
        expect_ev(9, EV_S);
        drive(1'b1, 3);
        drive(1'b0, 8);

        drive(1'b1, 3);
        drive(1'b0, 3);
        #2;
        rst    = 1'b0;
        exp_ev = 8'd0;
        #1;
        check_zero("rst_mid_gap");
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 10);

        p0 = n_pulses;
        for (int k = 0; k < 256; k++) begin
            expect_ev(9, EV_S);
            drive(1'b1, 3);
            drive(1'b0, 6);
        end
        check("wrap_pulse_count", n_pulses - p0, 256);
        check("wrap_ev_cnt", {24'd0, bus.ev_cnt}, 32'd0);

        check("scoreboard_empty", expq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
